// File: rtl/imem_program_loader.sv
// Instruction-memory loader: packs a big-endian byte stream into 32-bit words,
// writes them to sequential addresses while holding the CPU, and flags the first undecodable word.
module imem_program_loader #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  illegal,
    output logic [ADDR_WIDTH-1:0] illegal_addr
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE_W     = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [31:0]           word_q, word_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [ADDR_WIDTH:0]   target_q, target_d;
    logic                  illegal_q, illegal_d;
    logic [ADDR_WIDTH-1:0] illegal_addr_q, illegal_addr_d;

    logic                  handshake;
    logic [ADDR_WIDTH:0]   idx_next_w;

    // Decodable set of the control unit: R-type add/sub/and/or/slt, lw, sw, beq, addi, j.
    function automatic logic is_legal(input logic [31:0] w);
        logic ok;
        ok = 1'b0;
        case (w[31:26])
            6'b000000: begin
                case (w[5:0])
                    6'b100000, 6'b100010, 6'b100100,
                    6'b100101, 6'b101010: ok = 1'b1;
                    default:              ok = 1'b0;
                endcase
            end
            6'b100011, 6'b101011, 6'b000100,
            6'b001000, 6'b000010: ok = 1'b1;
            default:              ok = 1'b0;
        endcase
        return ok;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            word_q         <= '0;
            byte_cnt_q     <= '0;
            idx_q          <= '0;
            target_q       <= '0;
            illegal_q      <= 1'b0;
            illegal_addr_q <= '0;
        end else begin
            state_q        <= state_d;
            word_q         <= word_d;
            byte_cnt_q     <= byte_cnt_d;
            idx_q          <= idx_d;
            target_q       <= target_d;
            illegal_q      <= illegal_d;
            illegal_addr_q <= illegal_addr_d;
        end
    end

    assign handshake  = byte_valid & (state_q == S_RECV);
    assign idx_next_w = {1'b0, idx_q} + ONE_W;

    always_comb begin
        state_d        = state_q;
        word_d         = word_q;
        byte_cnt_d     = byte_cnt_q;
        idx_d          = idx_q;
        target_d       = target_q;
        illegal_d      = illegal_q;
        illegal_addr_d = illegal_addr_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Clamp keeps the word index from wrapping inside one session.
                    target_d       = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
                    idx_d          = '0;
                    byte_cnt_d     = '0;
                    illegal_d      = 1'b0;
                    illegal_addr_d = '0;
                    state_d        = (word_count == '0) ? S_DONE : S_RECV;
                end
            end
            S_RECV: begin
                if (handshake) begin
                    word_d     = {word_q[23:0], byte_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                idx_d   = idx_next_w[ADDR_WIDTH-1:0];
                state_d = (idx_next_w == target_q) ? S_DONE : S_RECV;
                if (!is_legal(word_q) && !illegal_q) begin
                    illegal_d      = 1'b1;
                    illegal_addr_d = idx_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Every output is a register or a decode of the state register.
    assign byte_ready   = (state_q == S_RECV);
    assign imem_we      = (state_q == S_WRITE);
    assign imem_addr    = idx_q;
    assign imem_wdata   = word_q;
    assign cpu_hold     = (state_q == S_RECV) || (state_q == S_WRITE);
    assign busy         = cpu_hold;
    assign done         = (state_q == S_DONE);
    assign illegal      = illegal_q;
    assign illegal_addr = illegal_addr_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader: write scoreboard plus cycle-accurate
// checks of handshake, hold, done, legality flag and reset behaviour.
module tb_imem_program_loader;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   word_count = '0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = '0;
    logic          byte_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          illegal;
    logic [AW-1:0] illegal_addr;

    imem_program_loader #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .word_count   (word_count),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .illegal      (illegal),
        .illegal_addr (illegal_addr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_writes = 0;
    logic [AW+31:0] exp_q[$];
    logic [AW+31:0] exp_w;
    logic [31:0]    prog[$];

    // Scoreboard: every memory write must match the next expected {addr, data}.
    always @(negedge clk) begin
        if (!reset && imem_we) begin
            n_writes++;
            n_cmp++;
            assert (exp_q.size() > 0) else begin
                n_bad++;
                $error("FAIL unexpected_write: observed addr=%0d data=%h expected no write", imem_addr, imem_wdata);
            end
            if (exp_q.size() > 0) begin
                exp_w = exp_q.pop_front();
                n_cmp++;
                assert ({imem_addr, imem_wdata} === exp_w) else begin
                    n_bad++;
                    $error("FAIL write: observed addr=%0d data=%h expected addr=%0d data=%h",
                           imem_addr, imem_wdata, exp_w[AW+31:32], exp_w[31:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int wc);
        start      = 1'b1;
        word_count = (AW+1)'(wc);
        step();
        start      = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && t < 50) begin
            step();
            t++;
        end
        check("byte_ready_timeout", {31'd0, byte_ready}, 32'd1);
        step();
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit toggle);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[31-8*i -: 8]);
            if (toggle) step();
        end
    endtask

    task automatic wait_done(input int budget);
        int t;
        t = 0;
        while (!done && t < budget) begin
            step();
            t++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic run_load(input int wc, input bit toggle);
        int n;
        n = (wc > (1 << AW)) ? (1 << AW) : wc;
        do_start(wc);
        check("illegal_cleared_on_start", {31'd0, illegal}, 32'd0);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({AW'(i), prog[i]});
            send_word(prog[i], toggle);
        end
        wait_done(20);
        check("queue_drained", exp_q.size(), 32'd0);
    endtask

    function automatic logic [31:0] rand_legal();
        logic [31:0] w;
        w = $urandom();
        case ($urandom_range(0, 5))
            0: begin
                w[31:26] = 6'b000000;
                case ($urandom_range(0, 4))
                    0:       w[5:0] = 6'b100000;
                    1:       w[5:0] = 6'b100010;
                    2:       w[5:0] = 6'b100100;
                    3:       w[5:0] = 6'b100101;
                    default: w[5:0] = 6'b101010;
                endcase
            end
            1:       w[31:26] = 6'b100011;
            2:       w[31:26] = 6'b101011;
            3:       w[31:26] = 6'b000100;
            4:       w[31:26] = 6'b001000;
            default: w[31:26] = 6'b000010;
        endcase
        return w;
    endfunction

    initial begin
        int w0;

        // Reset values
        #1;
        check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        check("rst_imem_we", {31'd0, imem_we}, 32'd0);
        check("rst_imem_addr", {26'd0, imem_addr}, 32'd0);
        check("rst_imem_wdata", imem_wdata, 32'd0);
        check("rst_hold_busy_done", {29'd0, cpu_hold, busy, done}, 32'd0);
        check("rst_illegal", {25'd0, illegal, illegal_addr}, 32'd0);
        step();
        step();
        reset = 1'b0;
        step();

        // Two-word load, exact cycle timing
        do_start(2);
        check("t1_recv_flags", {29'd0, byte_ready, busy, cpu_hold}, 32'd7);
        exp_q.push_back({AW'(0), 32'h02324020});
        exp_q.push_back({AW'(1), 32'h8C080004});
        send_word(32'h02324020, 1'b0);
        check("t1_we_cycle5", {31'd0, imem_we}, 32'd1);
        check("t1_addr_cycle5", {26'd0, imem_addr}, 32'd0);
        check("t1_data_cycle5", imem_wdata, 32'h02324020);
        check("t1_ready_in_write", {31'd0, byte_ready}, 32'd0);
        send_word(32'h8C080004, 1'b0);
        check("t1_we_cycle10", {31'd0, imem_we}, 32'd1);
        check("t1_addr_cycle10", {26'd0, imem_addr}, 32'd1);
        check("t1_data_cycle10", imem_wdata, 32'h8C080004);
        step();
        check("t1_done_cycle11", {31'd0, done}, 32'd1);
        check("t1_idle_flags_cycle11", {29'd0, busy, cpu_hold, byte_ready}, 32'd0);
        check("t1_illegal", {31'd0, illegal}, 32'd0);
        step();
        check("t1_done_cleared", {31'd0, done}, 32'd0);
        check("t1_queue", exp_q.size(), 32'd0);

        // Illegal third word in a 3-word load
        prog = '{32'h02324020, 32'h8C080004, 32'hFC000000};
        run_load(3, 1'b0);
        check("t2a_illegal", {31'd0, illegal}, 32'd1);
        check("t2a_illegal_addr", {26'd0, illegal_addr}, 32'd2);
        step();

        // Illegal 3rd and 4th words: first address sticks
        prog = '{32'h20010005, 32'h00221822, 32'hFC000000, 32'h00000001};
        run_load(4, 1'b0);
        check("t2b_illegal", {31'd0, illegal}, 32'd1);
        check("t2b_illegal_addr", {26'd0, illegal_addr}, 32'd2);
        step();

        // Byte valid toggling on a 1-word load
        w0 = n_writes;
        prog = '{32'hAC010008};
        run_load(1, 1'b1);
        check("t3_one_write", n_writes - w0, 32'd1);
        check("t3_illegal", {31'd0, illegal}, 32'd0);
        step();

        // Zero-word session
        w0 = n_writes;
        do_start(0);
        check("t4_done_next_cycle", {31'd0, done}, 32'd1);
        check("t4_no_hold", {30'd0, cpu_hold, busy}, 32'd0);
        step();
        check("t4_done_one_cycle", {31'd0, done}, 32'd0);
        check("t4_no_hold_after", {31'd0, cpu_hold}, 32'd0);
        check("t4_no_write", n_writes - w0, 32'd0);

        // Reset mid-session
        do_start(3);
        exp_q.push_back({AW'(0), 32'h02324020});
        exp_q.push_back({AW'(1), 32'hFC000000});
        send_word(32'h02324020, 1'b0);
        send_word(32'hFC000000, 1'b0);
        send_byte(8'h8C);
        send_byte(8'h08);
        check("t5_illegal_before_reset", {25'd0, illegal, illegal_addr}, {25'd0, 1'b1, 6'd1});
        w0 = n_writes;
        #2;
        reset = 1'b1;
        #1;
        check("t5_rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        check("t5_rst_imem_we", {31'd0, imem_we}, 32'd0);
        check("t5_rst_imem_addr", {26'd0, imem_addr}, 32'd0);
        check("t5_rst_imem_wdata", imem_wdata, 32'd0);
        check("t5_rst_hold_busy_done", {29'd0, cpu_hold, busy, done}, 32'd0);
        check("t5_rst_illegal", {25'd0, illegal, illegal_addr}, 32'd0);
        exp_q.delete();
        step();
        step();
        reset = 1'b0;
        step();
        check("t5_no_write_after_abort", n_writes - w0, 32'd0);
        prog = '{32'h08000010};
        run_load(1, 1'b0);
        step();

        // Start pulsed during RECV is ignored
        w0 = n_writes;
        do_start(1);
        exp_q.push_back({AW'(0), 32'h00851024});
        send_byte(8'h00);
        start      = 1'b1;
        word_count = '0;
        step();
        start      = 1'b0;
        check("t6_still_recv", {30'd0, busy, byte_ready}, 32'd3);
        send_byte(8'h85);
        send_byte(8'h10);
        send_byte(8'h24);
        check("t6_write_addr", {26'd0, imem_addr}, 32'd0);
        wait_done(20);
        check("t6_one_write", n_writes - w0, 32'd1);
        step();

        // word_count=127 clamps to 64 words
        prog.delete();
        for (int i = 0; i < 64; i++) prog.push_back(rand_legal());
        w0 = n_writes;
        run_load(127, 1'b0);
        check("t6_clamped_writes", n_writes - w0, 32'd64);
        check("t6_illegal", {31'd0, illegal}, 32'd0);
        step();
        check("t6_idle_after", {29'd0, busy, cpu_hold, done}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
